led_matrix_scanner: RTL and testbench

Self-timed, parametrised successor to the combinational LED array driver. Owns the column scan counter, a double-buffered frame image, per-column blanking and global PWM brightness. It drives a non-square ROWS x COLS active-high LED matrix directly from the Game of Life cell array. The scanner sits between the life-engine cell register and the board pins.

---
 rtl/led_matrix_pkg.sv | 7 +
 rtl/led_matrix_scanner_if.sv | 18 +
 rtl/led_scan_sequencer.sv | 50 +++++
 rtl/led_matrix_scanner.sv | 73 +++++++
 tb/tb_led_matrix_scanner.sv | 124 ++++++++++++
 5 files changed

// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: scan state type and one-hot helper shared by the LED matrix scanner.
package led_matrix_pkg;
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;
    function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned width);
        return (idx < width) ? 32'd1 << idx : 32'd0;
    endfunction
endpackage

// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: cell image, load handshake and pin-side outputs of the scanner.
interface led_matrix_scanner_if #(
    parameter int ROWS     = 5,
    parameter int COLS     = 5,
    parameter int PWM_BITS = 4
);
    logic                     ena;
    logic                     load;
    logic [ROWS*COLS-1:0]     cells;
    logic [PWM_BITS-1:0]      brightness;
    logic [ROWS-1:0]          rows;
    logic [COLS-1:0]          cols;
    logic [$clog2(COLS)-1:0]  x;
    logic                     frame_done;
    logic                     load_ack;
    modport master (output ena, load, cells, brightness, input rows, cols, x, frame_done, load_ack);
    modport slave  (input ena, load, cells, brightness, output rows, cols, x, frame_done, load_ack);
endinterface

// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer: column scan FSM with blank/dwell counters, column index and frame pulse.
module led_scan_sequencer
    import led_matrix_pkg::*;
#(
    parameter int COLS         = 5,
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 4,
    localparam int XW = $clog2(COLS),
    localparam int DW = $clog2(DWELL_CYCLES),
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    output scan_state_t   state,
    output logic [XW-1:0] x,
    output logic [DW-1:0] dwell_cnt,
    output logic          frame_done
);
    logic [BW-1:0] blank_cnt;
    logic          last;
    assign last = (x == XW'(COLS - 1));
    // Dropping ena outranks the column advance, so frame_done can never fire on that edge.
    always_ff @(posedge clk) begin
        frame_done <= 1'b0;
        if (rst || !ena) begin
            state     <= IDLE;
            x         <= '0;
            blank_cnt <= '0;
            dwell_cnt <= '0;
        end else if (state == IDLE) begin
            state     <= BLANK;
            blank_cnt <= '0;
        end else if (state == BLANK) begin
            if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
                state     <= DRIVE;
                dwell_cnt <= '0;
            end else begin
                blank_cnt <= blank_cnt + 1'b1;
            end
        end else if (dwell_cnt == DW'(DWELL_CYCLES - 1)) begin
            state      <= BLANK;
            blank_cnt  <= '0;
            x          <= last ? '0 : x + 1'b1;
            frame_done <= last;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: double-buffered, PWM-dimmed column scanner for a ROWS x COLS LED matrix.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS         = 5,
    parameter int COLS         = 5,
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 4,
    parameter int PWM_BITS     = 4
) (
    input logic                 clk,
    input logic                 rst,
    led_matrix_scanner_if.slave bus
);
    localparam int XW = $clog2(COLS);
    localparam int DW = $clog2(DWELL_CYCLES);
    scan_state_t          state;
    logic [XW-1:0]        x;
    logic [DW-1:0]        dwell_cnt;
    logic [DW-1:0]        phase;
    logic                 frame_done;
    logic [ROWS*COLS-1:0] shadow;
    logic [PWM_BITS-1:0]  bright_q;
    logic                 pending;
    logic                 load_ack;
    logic                 req;
    logic                 cap;
    logic                 drive;
    logic                 pwm_on;
    logic [COLS-1:0]      grid [ROWS];
    led_scan_sequencer #(
        .COLS         (COLS),
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .ena        (bus.ena),
        .state      (state),
        .x          (x),
        .dwell_cnt  (dwell_cnt),
        .frame_done (frame_done)
    );
    // New images only land in IDLE or on the frame boundary, so a frame is never torn.
    assign req = pending | bus.load;
    assign cap = req & ((state == IDLE) | frame_done);
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            bright_q <= '0;
            pending  <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= cap;
            pending  <= req & ~cap;
            if (cap) begin
                shadow   <= bus.cells;
                bright_q <= bus.brightness;
            end
        end
    end
    assign drive  = (state == DRIVE);
    assign phase  = dwell_cnt % DW'(2 ** PWM_BITS);
    assign pwm_on = phase < DW'(bright_q);
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign grid[r]     = shadow[r*COLS +: COLS];
        assign bus.rows[r] = drive & pwm_on & grid[r][x];
    end
    assign bus.cols       = drive ? COLS'(onehot(32'(x), COLS)) : '0;
    assign bus.x          = x;
    assign bus.frame_done = frame_done;
    assign bus.load_ack   = load_ack;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: directed and random stimulus against a timeline-arithmetic model of the scanner.
module tb_led_matrix_scanner;
    localparam int R = 3, C = 4, DWL = 16, BL = 2, PB = 2;
    localparam int P = BL + DWL, FP = C * P;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int k = 0;
    logic [R*C-1:0] sh = '0;
    logic [PB-1:0] br = '0;
    logic pend = 1'b0;
    logic ack_e = 1'b0;
    int ack_seen;
    led_matrix_scanner_if #(.ROWS(R), .COLS(C), .PWM_BITS(PB)) bus ();
    led_matrix_scanner #(
        .ROWS(R), .COLS(C), .DWELL_CYCLES(DWL), .BLANK_CYCLES(BL), .PWM_BITS(PB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    function automatic bit fd_of(int kk);
        return kk > 1 && (kk - 1) % FP == 0;
    endfunction
    function automatic int col_of(int kk);
        return kk == 0 ? 0 : ((kk - 1) / P) % C;
    endfunction
    function automatic int off_of(int kk);
        return kk == 0 ? 0 : (kk - 1) % P;
    endfunction
    function automatic bit drv_of(int kk);
        return kk > 0 && off_of(kk) >= BL;
    endfunction
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic r, input logic e, input logic l, input logic [R*C-1:0] c, input logic [PB-1:0] b);
        logic fd_cur, cap;
        logic [R-1:0] er;
        logic [C-1:0] ec;
        rst = r;
        bus.ena = e;
        bus.load = l;
        bus.cells = c;
        bus.brightness = b;
        fd_cur = fd_of(k);
        @(posedge clk);
        if (r) begin
            k = 0; sh = '0; br = '0; pend = 1'b0; ack_e = 1'b0;
        end else begin
            cap = (pend | l) && (k == 0 || fd_cur);
            ack_e = cap;
            if (cap) begin sh = c; br = b; end
            pend = (pend | l) && !cap;
            k = e ? k + 1 : 0;
        end
        #1;
        er = '0;
        ec = '0;
        if (drv_of(k)) begin
            ec[col_of(k)] = 1'b1;
            for (int i = 0; i < R; i++)
                er[i] = ((sh >> (i * C + col_of(k))) & 1) != 0 && ((off_of(k) - BL) % 4) < int'(br);
        end
        check("rows", 32'(bus.rows), 32'(er));
        check("cols", 32'(bus.cols), 32'(ec));
        check("x", 32'(bus.x), 32'(col_of(k)));
        check("frame_done", 32'(bus.frame_done), 32'(fd_of(k)));
        check("load_ack", 32'(bus.load_ack), 32'(ack_e));
        if (bus.load_ack) ack_seen++;
    endtask
    task automatic run(input int n, input logic [R*C-1:0] c, input logic [PB-1:0] b);
        for (int i = 0; i < n; i++) step(0, 1, 0, c, b);
    endtask
    task automatic run_to(input int col, input logic e);
        int n = 0;
        while (!(drv_of(k) && col_of(k) == col && off_of(k) == BL + 5) && n < 400) begin
            step(0, e, 0, '0, '0);
            n++;
        end
        if (n >= 400) begin
            failures++;
            $display("FAIL run_to col=%0d timeout observed=%0d required<400", col, n);
        end
    endtask
    initial begin
        step(1, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0);
        step(0, 0, 1, '1, 2'd3);
        step(0, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        step(0, 0, 1, 12'h040, 2'd3);
        run(2 * FP + 10, '0, '0);
        step(0, 1, 1, 12'h040, 2'd0);
        run(FP + 10, '0, '0);
        step(0, 1, 1, 12'h040, 2'd3);
        run(FP, '0, '0);
        run_to(1, 1);
        ack_seen = 0;
        step(0, 1, 1, 12'($urandom), 2'd2);
        run(5, '0, '0);
        step(0, 1, 1, 12'hA5F, 2'd3);
        while (!fd_of(k)) step(0, 1, 0, '0, '0);
        run(2 * P, '0, '0);
        check("single_ack", 32'(ack_seen), 32'd1);
        run_to(2, 1);
        step(0, 0, 0, '0, '0);
        run(2 * FP, '0, '0);
        run_to(1, 1);
        step(1, 1, 0, '0, '0);
        run(FP + 5, '0, '0);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 399) == 0, $urandom_range(0, 59) != 0, $urandom_range(0, 15) == 0,
                 12'($urandom), 2'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
